// File: rtl/pwr_seq_pkg.sv
// Shared types and constants for the programmable rail-group sequencer.
package pwr_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PU_QUAL,
    PU_DLY,
    ON,
    PD,
    RSTRT_DLY,
    LOCKOUT
  } seq_state_t;

  localparam logic [2:0] RETRY_INF = 3'h7;
  localparam logic [2:0] RETRY_SAT = 3'h6;

endpackage

// File: rtl/pwr_seq_timer.sv
// Shared saturating delay timer with a live >= compare against the active limit.
module pwr_seq_timer #(
  parameter int unsigned DLY_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DLY_W-1:0] limit,
  output logic             expired
);

  logic [DLY_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + DLY_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q >= limit);

endmodule

// File: rtl/pwr_group_sequencer.sv
// Register-programmable rail-group sequencer: ordered power-up with PG qualification,
// reverse or simultaneous power-down, first-fault logging and retry/lockout policy.
module pwr_group_sequencer
  import pwr_seq_pkg::*;
#(
  parameter int unsigned PWR_GROUPS = 8,
  parameter int unsigned DLY_W      = 16
) (
  input  logic                        CLOCK,
  input  logic                        RESET,
  input  logic                        ENABLE,
  input  logic                        VIN_FAULT,
  input  logic [PWR_GROUPS-1:0]       GROUP_PWRGD,
  input  logic [PWR_GROUPS*DLY_W-1:0] REG_UPDLY,
  input  logic [DLY_W-1:0]            REG_QUALDLY,
  input  logic [DLY_W-1:0]            REG_DNDLY,
  input  logic                        REG_DN_MODE,
  input  logic [PWR_GROUPS-1:0]       REG_FAULT_MASK,
  input  logic [2:0]                  REG_RETRIES,
  input  logic [DLY_W-1:0]            REG_RSTRT_DLY,
  output logic [PWR_GROUPS-1:0]       VRAIL_ENA,
  output logic                        PWR_GOOD,
  output logic                        nFAULT,
  output logic [PWR_GROUPS-1:0]       FAULT_LOG,
  output logic                        DCHG_TMO,
  output logic [2:0]                  RETRY_CNT
);

  localparam int unsigned IDX_W = (PWR_GROUPS > 1) ? $clog2(PWR_GROUPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PWR_GROUPS - 1);

  seq_state_t            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [PWR_GROUPS-1:0] ena_q, ena_d;
  logic [PWR_GROUPS-1:0] qual_q, qual_d;
  logic [PWR_GROUPS-1:0] log_q, log_d;
  logic                  pd_dly_q, pd_dly_d;
  logic                  nfault_q, nfault_d;
  logic                  dchg_q, dchg_d;
  logic                  pwr_good_q, pwr_good_d;
  logic [2:0]            cnt_q, cnt_d;

  logic [PWR_GROUPS-1:0] idx_oh, pg_loss, grp_flt, flt_first;
  logic                  pu_or_on, tmo_flt, flt, pd_done;
  logic                  tmr_clr, tmr_en, tmr_exp;
  logic [DLY_W-1:0]      tmr_limit;

  pwr_seq_timer #(.DLY_W(DLY_W)) u_timer (
    .clk     (CLOCK),
    .rst     (RESET),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .limit   (tmr_limit),
    .expired (tmr_exp)
  );

  // Fault sources: lost PG on qualified unmasked groups plus the PU_QUAL timeout.
  always_comb begin
    idx_oh         = '0;
    idx_oh[idx_q]  = 1'b1;
    pu_or_on  = (state_q == PU_QUAL) || (state_q == PU_DLY) || (state_q == ON);
    tmo_flt   = (state_q == PU_QUAL) && !GROUP_PWRGD[idx_q] && tmr_exp;
    pg_loss   = qual_q & ~GROUP_PWRGD & ~REG_FAULT_MASK;
    grp_flt   = pg_loss | (tmo_flt ? idx_oh : '0);
    flt_first = grp_flt & (~grp_flt + PWR_GROUPS'(1));
    flt       = pu_or_on && (VIN_FAULT || (|grp_flt));
    tmr_en    = (state_q == PU_QUAL) || (state_q == PU_DLY) ||
                (state_q == PD) || (state_q == RSTRT_DLY);
    case (state_q)
      PU_QUAL:   tmr_limit = REG_QUALDLY;
      PU_DLY:    tmr_limit = REG_UPDLY[idx_q*DLY_W +: DLY_W];
      PD:        tmr_limit = (pd_dly_q && !REG_DN_MODE) ? REG_DNDLY : REG_QUALDLY;
      RSTRT_DLY: tmr_limit = REG_RSTRT_DLY;
      default:   tmr_limit = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ena_d    = ena_q;
    qual_d   = qual_q;
    log_d    = log_q;
    pd_dly_d = pd_dly_q;
    nfault_d = nfault_q;
    dchg_d   = dchg_q;
    cnt_d    = cnt_q;
    pd_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ENABLE && !VIN_FAULT && (GROUP_PWRGD == '0)) begin
          state_d  = PU_QUAL;
          idx_d    = '0;
          ena_d    = '0;
          ena_d[0] = 1'b1;
        end
      end
      PU_QUAL, PU_DLY, ON: begin
        if (flt || !ENABLE) begin
          state_d  = PD;
          pd_dly_d = 1'b0;
          qual_d   = '0;
          if (REG_DN_MODE) ena_d = '0;
          else             ena_d[idx_q] = 1'b0;
          if (flt) begin
            nfault_d = 1'b0;
            if (log_q == '0) log_d = flt_first;
          end
        end else if (state_q == PU_QUAL) begin
          if (GROUP_PWRGD[idx_q]) begin
            qual_d[idx_q] = 1'b1;
            state_d       = PU_DLY;
          end
        end else if ((state_q == PU_DLY) && tmr_exp) begin
          if (idx_q == LAST_IDX) begin
            state_d = ON;
          end else begin
            idx_d                      = idx_q + IDX_W'(1);
            ena_d[idx_q + IDX_W'(1)]   = 1'b1;
            state_d                    = PU_QUAL;
          end
        end
      end
      PD: begin
        // pd_dly_q splits each reverse step into discharge wait then DNDLY wait.
        if (REG_DN_MODE) begin
          ena_d    = '0;
          pd_dly_d = 1'b0;
          if (GROUP_PWRGD == '0) begin
            pd_done = 1'b1;
          end else if (tmr_exp) begin
            dchg_d  = 1'b1;
            pd_done = 1'b1;
          end
        end else if (!pd_dly_q) begin
          if (!GROUP_PWRGD[idx_q] || tmr_exp) begin
            if (GROUP_PWRGD[idx_q]) dchg_d = 1'b1;
            if (idx_q == '0) pd_done  = 1'b1;
            else             pd_dly_d = 1'b1;
          end
        end else if (tmr_exp) begin
          idx_d                    = idx_q - IDX_W'(1);
          ena_d[idx_q - IDX_W'(1)] = 1'b0;
          pd_dly_d                 = 1'b0;
        end
        if (pd_done) begin
          if (nfault_q)                                             state_d = IDLE;
          else if ((REG_RETRIES == RETRY_INF) || (cnt_q < REG_RETRIES)) state_d = RSTRT_DLY;
          else                                                      state_d = LOCKOUT;
        end
      end
      RSTRT_DLY: begin
        if (!ENABLE) begin
          state_d  = IDLE;
          cnt_d    = '0;
          log_d    = '0;
          dchg_d   = 1'b0;
          nfault_d = 1'b1;
        end else if (tmr_exp) begin
          state_d  = IDLE;
          log_d    = '0;
          nfault_d = 1'b1;
          if ((REG_RETRIES != RETRY_INF) && (cnt_q != RETRY_SAT)) cnt_d = cnt_q + 3'd1;
        end
      end
      LOCKOUT: begin
        if (!ENABLE) begin
          state_d  = IDLE;
          cnt_d    = '0;
          log_d    = '0;
          dchg_d   = 1'b0;
          nfault_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    pwr_good_d = (state_d == ON);
    tmr_clr    = (state_d != state_q) || (idx_d != idx_q) || (pd_dly_d != pd_dly_q);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      ena_q      <= '0;
      qual_q     <= '0;
      log_q      <= '0;
      pd_dly_q   <= 1'b0;
      nfault_q   <= 1'b1;
      dchg_q     <= 1'b0;
      pwr_good_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ena_q      <= ena_d;
      qual_q     <= qual_d;
      log_q      <= log_d;
      pd_dly_q   <= pd_dly_d;
      nfault_q   <= nfault_d;
      dchg_q     <= dchg_d;
      pwr_good_q <= pwr_good_d;
      cnt_q      <= cnt_d;
    end
  end

  assign VRAIL_ENA = ena_q;
  assign PWR_GOOD  = pwr_good_q;
  assign nFAULT    = nfault_q;
  assign FAULT_LOG = log_q;
  assign DCHG_TMO  = dchg_q;
  assign RETRY_CNT = cnt_q;

endmodule

// File: tb/tb_pwr_group_sequencer.sv
// Directed-random bench: expected event latencies are derived from the sequencing rules
// as cycle arithmetic (delay N -> N+1 edges after entry, plus input sampling edge).
module tb_pwr_group_sequencer;

  localparam int N = 4;
  localparam int W = 8;

  logic           CLOCK = 1'b0;
  logic           RESET;
  logic           ENABLE;
  logic           VIN_FAULT;
  logic [N-1:0]   pg;
  logic [N*W-1:0] REG_UPDLY;
  logic [W-1:0]   REG_QUALDLY, REG_DNDLY, REG_RSTRT_DLY;
  logic           REG_DN_MODE;
  logic [N-1:0]   REG_FAULT_MASK;
  logic [2:0]     REG_RETRIES;
  logic [N-1:0]   VRAIL_ENA;
  logic           PWR_GOOD, nFAULT, DCHG_TMO;
  logic [N-1:0]   FAULT_LOG;
  logic [2:0]     RETRY_CNT;

  int vectors = 0;
  int miscompares = 0;
  int updly_v [N];
  int exp_cnt = 0;

  pwr_group_sequencer #(.PWR_GROUPS(N), .DLY_W(W)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .ENABLE(ENABLE), .VIN_FAULT(VIN_FAULT),
    .GROUP_PWRGD(pg), .REG_UPDLY(REG_UPDLY), .REG_QUALDLY(REG_QUALDLY),
    .REG_DNDLY(REG_DNDLY), .REG_DN_MODE(REG_DN_MODE), .REG_FAULT_MASK(REG_FAULT_MASK),
    .REG_RETRIES(REG_RETRIES), .REG_RSTRT_DLY(REG_RSTRT_DLY),
    .VRAIL_ENA(VRAIL_ENA), .PWR_GOOD(PWR_GOOD), .nFAULT(nFAULT),
    .FAULT_LOG(FAULT_LOG), .DCHG_TMO(DCHG_TMO), .RETRY_CNT(RETRY_CNT)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic get_sig(input int sel);
    if (sel < N)      return VRAIL_ENA[sel];
    if (sel == N)     return PWR_GOOD;
    if (sel == N + 1) return nFAULT;
    return DCHG_TMO;
  endfunction

  // Steps until the selected output reaches v; n = steps taken, -1 on budget expiry.
  task automatic wait_sig(input int sel, input logic v, input int budget, output int n);
    n = 0;
    while ((get_sig(sel) !== v) && (n < budget)) begin
      step();
      n++;
    end
    if (get_sig(sel) !== v) n = -1;
  endtask

  task automatic drive_updly();
    for (int i = 0; i < N; i++) REG_UPDLY[i*W +: W] = W'(updly_v[i]);
  endtask

  // Called right after ENA[0] rose; completes the up-sequence to ON.
  task automatic pu_from_ena0();
    int n;
    int d;
    for (int i = 0; i < N; i++) updly_v[i] = int'($urandom_range(0, 6));
    drive_updly();
    for (int i = 0; i < N; i++) begin
      d = int'($urandom_range(0, 5));
      repeat (d) step();
      pg[i] = 1'b1;
      if (i < N - 1) begin
        wait_sig(i + 1, 1'b1, 60, n);
        chk("pu_ena_gap", n, updly_v[i] + 2);
        chk("pu_ena_pattern", VRAIL_ENA, (1 << (i + 2)) - 1);
      end else begin
        wait_sig(N, 1'b1, 60, n);
        chk("pwr_good_gap", n, updly_v[i] + 2);
        chk("on_ena", VRAIL_ENA, {N{1'b1}});
      end
    end
  endtask

  // Called right after ENA[start] fell in reverse PD; returns right after PG[0] drops.
  task automatic pd_reverse(input int start);
    int n;
    int k;
    for (int i = start; i >= 0; i--) begin
      k = pg[i] ? int'($urandom_range(0, 3)) : 0;
      repeat (k) step();
      pg[i] = 1'b0;
      if (i > 0) begin
        wait_sig(i - 1, 1'b0, 60, n);
        chk("pd_ena_gap", n, int'(REG_DNDLY) + 2);
      end
    end
  endtask

  initial begin
    int n;
    int g;
    int q;
    int d;
    RESET = 1'b1; ENABLE = 1'b0; VIN_FAULT = 1'b0; pg = '0;
    REG_QUALDLY = 8'd12; REG_DNDLY = 8'd3; REG_RSTRT_DLY = 8'd2;
    REG_DN_MODE = 1'b0; REG_FAULT_MASK = '0; REG_RETRIES = 3'd3;
    for (int i = 0; i < N; i++) updly_v[i] = 2;
    drive_updly();
    repeat (3) step();
    RESET = 1'b0;
    step();
    chk("rst_ena", VRAIL_ENA, 0);
    chk("rst_pwr_good", PWR_GOOD, 0);
    chk("rst_nfault", nFAULT, 1);
    chk("rst_log", FAULT_LOG, 0);
    chk("rst_dchg", DCHG_TMO, 0);
    chk("rst_cnt", RETRY_CNT, 0);

    // Ordered power-up
    ENABLE = 1'b1;
    wait_sig(0, 1'b1, 10, n);
    chk("ena0_latency", n, 1);
    pu_from_ena0();

    // Unmasked PG loss in ON, reverse power-down, restart
    for (int it = 0; it < 3; it++) begin
      g = int'($urandom_range(0, N - 1));
      REG_DNDLY     = W'($urandom_range(0, 5));
      REG_RSTRT_DLY = W'($urandom_range(0, 5));
      REG_RETRIES   = $urandom_range(0, 1) ? 3'd7 : 3'd3;
      pg[g] = 1'b0;
      step();
      chk("flt_nfault", nFAULT, 0);
      chk("flt_log", FAULT_LOG, 1 << g);
      chk("flt_ena_top_off", VRAIL_ENA, {1'b0, {(N-1){1'b1}}});
      chk("flt_pwr_good", PWR_GOOD, 0);
      pd_reverse(N - 1);
      wait_sig(N + 1, 1'b1, 60, n);
      chk("rstrt_gap", n, int'(REG_RSTRT_DLY) + 2);
      if (REG_RETRIES != 3'd7) exp_cnt++;
      chk("retry_cnt", RETRY_CNT, exp_cnt);
      chk("log_cleared", FAULT_LOG, 0);
      wait_sig(0, 1'b1, 10, n);
      chk("reup_latency", n, 1);
      pu_from_ena0();
    end

    // Masked PG loss is ignored
    g = int'($urandom_range(0, N - 1));
    REG_FAULT_MASK[g] = 1'b1;
    pg[g] = 1'b0;
    repeat (8) step();
    chk("mask_pwr_good", PWR_GOOD, 1);
    chk("mask_nfault", nFAULT, 1);
    chk("mask_ena", VRAIL_ENA, {N{1'b1}});
    pg[g] = 1'b1;
    step();
    REG_FAULT_MASK = '0;

    // Orderly reverse power-down without fault
    REG_DNDLY = W'($urandom_range(0, 5));
    ENABLE = 1'b0;
    wait_sig(N - 1, 1'b0, 10, n);
    chk("pd_first_latency", n, 1);
    pd_reverse(N - 1);
    step();
    chk("pd_ena_off", VRAIL_ENA, 0);
    chk("pd_nfault", nFAULT, 1);
    chk("pd_dchg", DCHG_TMO, 0);
    chk("pd_cnt_kept", RETRY_CNT, exp_cnt);
    ENABLE = 1'b1;
    wait_sig(0, 1'b1, 10, n);
    chk("idle_reup", n, 1);
    pu_from_ena0();
    RESET = 1'b1;
    step();
    chk("rst_on_ena", VRAIL_ENA, 0);
    chk("rst_on_cnt", RETRY_CNT, 0);
    RESET = 1'b0; ENABLE = 1'b0; pg = '0;
    step();

    // PG[1] never rises: QUALDLY timeout, two retries then lockout
    REG_RETRIES = 3'd2;
    q = int'($urandom_range(10, 20));
    REG_QUALDLY   = W'(q);
    REG_DNDLY     = W'($urandom_range(0, 5));
    REG_RSTRT_DLY = W'($urandom_range(0, 5));
    updly_v[0] = int'($urandom_range(0, 6));
    drive_updly();
    ENABLE = 1'b1;
    wait_sig(0, 1'b1, 10, n);
    chk("tmo_ena0", n, 1);
    for (int a = 0; a < 3; a++) begin
      d = int'($urandom_range(0, 5));
      repeat (d) step();
      pg[0] = 1'b1;
      wait_sig(1, 1'b1, 60, n);
      chk("tmo_ena1_gap", n, updly_v[0] + 2);
      wait_sig(N + 1, 1'b0, 100, n);
      chk("tmo_fault_time", n, q + 1);
      chk("tmo_log", FAULT_LOG, 2);
      chk("tmo_ena", VRAIL_ENA, 1);
      pd_reverse(1);
      if (a < 2) begin
        wait_sig(N + 1, 1'b1, 60, n);
        chk("tmo_rstrt_gap", n, int'(REG_RSTRT_DLY) + 2);
        chk("tmo_retry_cnt", RETRY_CNT, a + 1);
        wait_sig(0, 1'b1, 10, n);
        chk("tmo_reup", n, 1);
      end else begin
        repeat (6) step();
        chk("lock_ena", VRAIL_ENA, 0);
        chk("lock_nfault", nFAULT, 0);
        chk("lock_log", FAULT_LOG, 2);
        chk("lock_cnt", RETRY_CNT, 2);
      end
    end
    ENABLE = 1'b0;
    step();
    chk("unlock_cnt", RETRY_CNT, 0);
    chk("unlock_nfault", nFAULT, 1);
    chk("unlock_log", FAULT_LOG, 0);
    REG_QUALDLY = 8'd10;

    // Simultaneous power-down with PG[0] stuck high
    ENABLE = 1'b1;
    wait_sig(0, 1'b1, 10, n);
    chk("sim_ena0", n, 1);
    pu_from_ena0();
    REG_DN_MODE = 1'b1;
    ENABLE = 1'b0;
    step();
    chk("sim_all_off", VRAIL_ENA, 0);
    pg[N-1:1] = '0;
    wait_sig(N + 2, 1'b1, 40, n);
    chk("sim_dchg_time", n, 11);
    chk("sim_nfault", nFAULT, 1);
    pg[0] = 1'b0;
    REG_DN_MODE = 1'b0;
    ENABLE = 1'b1;
    wait_sig(0, 1'b1, 10, n);
    chk("sim_idle_reup", n, 1);
    chk("dchg_sticky", DCHG_TMO, 1);
    pu_from_ena0();

    // VIN fault and PG[3] loss on the same edge
    VIN_FAULT = 1'b1;
    pg[N-1] = 1'b0;
    step();
    chk("vin_pg_nfault", nFAULT, 0);
    chk("vin_pg_log", FAULT_LOG, 1 << (N - 1));
    chk("vin_pg_ena", VRAIL_ENA, {1'b0, {(N-1){1'b1}}});
    RESET = 1'b1; VIN_FAULT = 1'b0; pg = '0;
    step();
    chk("rst2_dchg", DCHG_TMO, 0);
    chk("rst2_log", FAULT_LOG, 0);
    RESET = 1'b0;

    // Reset while in PU_DLY
    updly_v[0] = 5;
    drive_updly();
    wait_sig(0, 1'b1, 10, n);
    chk("rst3_ena0", n, 1);
    pg[0] = 1'b1;
    step();
    step();
    RESET = 1'b1;
    step();
    chk("rst_pudly_ena", VRAIL_ENA, 0);
    chk("rst_pudly_pwr_good", PWR_GOOD, 0);
    chk("rst_pudly_nfault", nFAULT, 1);
    chk("rst_pudly_log", FAULT_LOG, 0);
    chk("rst_pudly_cnt", RETRY_CNT, 0);
    RESET = 1'b0; ENABLE = 1'b0; pg = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
